vcmac_job_sequencer: RTL and testbench

//  Initiator-side controller for the vector complex MAC array. It walks a job of LEN operand words

---
 rtl/vcmac_pkg.sv | 19 +
 rtl/vcmac_issue_cnt.sv | 47 ++++
 rtl/vcmac_job_sequencer.sv | 153 +++++++++++++++
 tb/tb_vcmac_job_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcmac_pkg.sv
// vcmac_pkg
//   Shared constants and state encoding for the vector complex MAC job sequencer.
//   VCMAC_ADDR_W : default operand address / job length width
//   VCMAC_RD_LAT : operand RAM read latency; the sequencer's MAC-control delay is built for 1
//   seq_state_t  : sequencer state encoding (IDLE, ISSUE, DRAIN, RESULT, DONE)
package vcmac_pkg;

    localparam int unsigned VCMAC_ADDR_W = 10;
    localparam int unsigned VCMAC_RD_LAT = 1;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_ISSUE  = 3'd1;
    localparam seq_state_t ST_DRAIN  = 3'd2;
    localparam seq_state_t ST_RESULT = 3'd3;
    localparam seq_state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/vcmac_issue_cnt.sv
// vcmac_issue_cnt
//   Granted-read counter for the job sequencer. Holds the next operand address (base + issued
//   count, wrapping modulo 2^ADDR_W) and the number of reads still to be issued.
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : accept a new job (loads i_base / i_len)
//   i_base       : first operand address
//   i_len        : number of operand words in the job
//   i_issue      : a read was granted this cycle
//   o_addr       : address of the next read
//   o_last       : the next granted read is the final one of the job
module vcmac_issue_cnt
    import vcmac_pkg::*;
#(
    parameter int unsigned ADDR_W = VCMAC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_issue,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_left;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_left <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_left <= i_len;
        end else if (i_issue) begin
            // Natural overflow of the adder gives the modulo-2^ADDR_W wrap.
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_left == ADDR_W'(1));

endmodule

// File: rtl/vcmac_job_sequencer.sv
// vcmac_job_sequencer
//   Initiator-side controller for the vector complex MAC array. Walks a job of i_len operand words
//   through the operand RAM, drives the MAC write/load/accumulate/abs controls aligned with the
//   returning read data, collects a sticky overflow flag and presents the final result to a sink
//   with a valid/ready handshake.
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start, i_len, i_base,
//   i_abs_mode              : job request and its parameters (sampled when accepted in IDLE)
//   o_rd_en, o_rd_addr,
//   i_rd_gnt                : operand RAM read port; a read issues on o_rd_en & i_rd_gnt
//   o_w_en, o_mult, o_acc,
//   o_abs, i_overflow       : MAC control pins and overflow indication
//   o_res_valid, i_res_ready: result handshake
//   o_busy, o_done,
//   o_ovf_flag              : job status
module vcmac_job_sequencer
    import vcmac_pkg::*;
#(
    parameter int unsigned ADDR_W = VCMAC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_abs_mode,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_gnt,
    output logic              o_w_en,
    output logic              o_mult,
    output logic              o_acc,
    output logic              o_abs,
    input  logic              i_overflow,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovf_flag
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic              r_abs;
    logic              r_wen;        // read granted last cycle: data is at the MAC now
    logic              r_first;      // the word in r_wen is word 0 of the job
    logic              r_first_pend; // no read of this job has been granted yet
    logic              r_arm;        // first MAC write has happened; overflow is meaningful
    logic              r_ovf;

    logic              w_accept;
    logic              w_issue;
    logic              w_last;
    logic              w_sample_st;
    logic [ADDR_W-1:0] w_addr;

    assign w_accept    = (r_state == ST_IDLE) & i_start;
    assign w_issue     = (r_state == ST_ISSUE) & i_rd_gnt;
    assign w_sample_st = (r_state == ST_ISSUE) | (r_state == ST_DRAIN) | (r_state == ST_RESULT);

    vcmac_issue_cnt #(
        .ADDR_W (ADDR_W)
    ) u_issue_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_accept),
        .i_base  (i_base),
        .i_len   (i_len),
        .i_issue (w_issue),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            // First DRAIN cycle carries the last MAC write; the cycle after it lets the
            // registered MAC output settle before the result is offered.
            ST_DRAIN: begin
                if (!r_wen) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (i_res_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_abs        <= 1'b0;
            r_wen        <= 1'b0;
            r_first      <= 1'b0;
            r_first_pend <= 1'b0;
            r_arm        <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wen   <= w_issue;
            r_first <= w_issue & r_first_pend;
            if (w_accept) begin
                r_abs        <= i_abs_mode;
                r_first_pend <= 1'b1;
                r_arm        <= 1'b0;
                r_ovf        <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_first_pend <= 1'b0;
                end
                if (r_wen && r_first) begin
                    r_arm <= 1'b1;
                end
                if (r_arm && w_sample_st) begin
                    r_ovf <= r_ovf | i_overflow;
                end
            end
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_rd_en     = (r_state == ST_ISSUE);
    assign o_rd_addr   = o_rd_en ? w_addr : '0;
    assign o_w_en      = r_wen;
    assign o_mult      = r_wen & r_first;
    assign o_acc       = r_wen & ~r_first;
    assign o_abs       = r_abs & o_busy;
    assign o_res_valid = (r_state == ST_RESULT);
    assign o_done      = (r_state == ST_DONE);
    assign o_ovf_flag  = r_ovf;

endmodule

// File: tb/tb_vcmac_job_sequencer.sv
module tb_vcmac_job_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] len = '0;
    logic [9:0] base = '0;
    logic       abs_mode = 1'b0;
    logic       rd_gnt = 1'b0;
    logic       overflow = 1'b0;
    logic       res_ready = 1'b0;
    logic       rd_en, w_en, mult, acc, abs_o, res_valid, busy, done, ovf_flag;
    logic [9:0] rd_addr;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vcmac_job_sequencer #(
        .ADDR_W (10)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_len       (len),
        .i_base      (base),
        .i_abs_mode  (abs_mode),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_gnt    (rd_gnt),
        .o_w_en      (w_en),
        .o_mult      (mult),
        .o_acc       (acc),
        .o_abs       (abs_o),
        .i_overflow  (overflow),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_ovf_flag  (ovf_flag)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: timestamp/count based ----------------
    int  cyc = 0;
    bit  m_valid = 0;
    bit  m_act = 0;
    int  m_len = 0, m_base = 0, m_k = 0, m_written = 0, m_last_wr = 0, m_done_cyc = 0;
    int  m_wq_idx = 0;
    bit  m_abs = 0, m_wq = 0, m_ovf = 0, m_armed = 0, m_xfer = 0;

    initial begin : model
        bit e_rd_en, e_wen, e_mult, e_acc, e_abs, e_rv, e_busy, e_done;
        logic [9:0] e_addr;
        logic [31:0] e_vec, a_vec;
        forever begin
            @(negedge clk);
            e_rd_en = m_act && (m_k < m_len);
            e_addr  = e_rd_en ? 10'((m_base + m_k) % 1024) : 10'd0;
            e_wen   = m_wq;
            e_mult  = m_wq && (m_wq_idx == 0);
            e_acc   = m_wq && (m_wq_idx != 0);
            e_abs   = m_act && m_abs;
            e_rv    = m_act && (m_len > 0) && (m_written == m_len) &&
                      (cyc >= m_last_wr + 2) && !m_xfer;
            e_busy  = m_act;
            e_done  = m_act && (cyc == m_done_cyc);
            e_vec = {13'd0, e_rd_en, e_addr, e_wen, e_mult, e_acc, e_abs, e_rv, e_busy, e_done,
                     m_ovf};
            a_vec = {13'd0, rd_en, rd_addr, w_en, mult, acc, abs_o, res_valid, busy, done,
                     ovf_flag};
            if (m_valid) chk("cycle_outputs", a_vec, e_vec);
            @(posedge clk);
            if (rst) begin
                m_valid = 1; m_act = 0; m_wq = 0; m_ovf = 0; m_k = 0; m_len = 0;
                m_xfer = 0; m_armed = 0;
            end else if (!m_act) begin
                m_wq = 0;
                if (start) begin
                    m_act = 1; m_len = int'(len); m_base = int'(base); m_abs = abs_mode;
                    m_k = 0; m_written = 0; m_xfer = 0; m_ovf = 0; m_armed = 0;
                    m_done_cyc = (len == 0) ? cyc + 1 : 32'h7fff_ffff;
                end
            end else if (cyc == m_done_cyc) begin
                m_act = 0; m_wq = 0;
            end else begin
                if (m_armed && !m_xfer) m_ovf = m_ovf | overflow;
                if (m_wq) begin
                    m_written++;
                    m_last_wr = cyc;
                    if (m_wq_idx == 0) m_armed = 1;
                end
                m_wq = e_rd_en && rd_gnt;
                m_wq_idx = m_k;
                if (m_wq) m_k++;
                if (e_rv && res_ready) begin
                    m_xfer = 1;
                    m_done_cyc = cyc + 1;
                end
            end
            cyc++;
        end
    end

    // ---------------- directed job runner with per-cycle trace ----------------
    logic       tr_rd_en [0:39];
    logic [9:0] tr_addr  [0:39];
    logic       tr_wen   [0:39];
    logic       tr_mult  [0:39];
    logic       tr_abs   [0:39];
    logic       tr_rv    [0:39];
    logic       tr_busy  [0:39];
    logic       tr_done  [0:39];
    logic       tr_ovf   [0:39];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 of the trace is the cycle in which start is accepted.
    task automatic run_job(input int l, input int b, input bit am, input logic [31:0] gpat,
                           input int ready_from, input int again_cyc, input int ovf_cyc,
                           input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == again_cyc);
            len       = 10'((c == 0) ? l : 5);
            base      = 10'(b);
            abs_mode  = am;
            rd_gnt    = (c >= 1 && c <= 32) ? gpat[c-1] : 1'b1;
            res_ready = (c >= ready_from);
            overflow  = (c == ovf_cyc);
            @(negedge clk);
            tr_rd_en[c] = rd_en; tr_addr[c] = rd_addr; tr_wen[c] = w_en; tr_mult[c] = mult;
            tr_abs[c] = abs_o; tr_rv[c] = res_valid; tr_busy[c] = busy; tr_done[c] = done;
            tr_ovf[c] = ovf_flag;
            step();
        end
        start = 0;
        overflow = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        start = 0;
        rd_gnt = 1;
        res_ready = 1;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        step();
    endtask

    initial begin
        int cnt;
        // reset
        rst = 1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_outputs", {13'd0, rd_en, rd_addr, w_en, mult, acc, abs_o, res_valid, busy,
                              done, ovf_flag}, 32'd0);
        step();
        rst = 0;
        step();

        // 1: len=4 base=0x10 gap-free, abs job
        run_job(4, 'h10, 1'b1, 32'hFFFF_FFFF, 0, -1, -1, 12);
        for (int c = 0; c < 12; c++) begin
            chk("t1_rd_en", {31'd0, tr_rd_en[c]}, {31'd0, (c >= 1 && c <= 4)});
            if (c >= 1 && c <= 4) chk("t1_rd_addr", {22'd0, tr_addr[c]}, 32'h10 + c - 1);
            chk("t1_w_en", {31'd0, tr_wen[c]}, {31'd0, (c >= 2 && c <= 5)});
            chk("t1_mult", {31'd0, tr_mult[c]}, {31'd0, (c == 2)});
            chk("t1_abs", {31'd0, tr_abs[c]}, {31'd0, (c >= 1 && c <= 8)});
            chk("t1_res_valid", {31'd0, tr_rv[c]}, {31'd0, (c == 7)});
            chk("t1_done", {31'd0, tr_done[c]}, {31'd0, (c == 8)});
        end
        wait_idle();

        // 2: len=3 grant pattern 1,0,0,1,1 -> writes at 2,5,6; result two cycles later
        run_job(3, 'h40, 1'b0, 32'hFFFF_FFF9, 0, -1, -1, 12);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (tr_wen[c]) cnt++;
            chk("t2_w_en", {31'd0, tr_wen[c]}, {31'd0, (c == 2 || c == 5 || c == 6)});
            chk("t2_mult", {31'd0, tr_mult[c]}, {31'd0, (c == 2)});
            chk("t2_res_valid", {31'd0, tr_rv[c]}, {31'd0, (c == 8)});
        end
        chk("t2_w_en_count", cnt, 3);
        wait_idle();

        // 3: len=0 -> straight to DONE
        run_job(0, 'h55, 1'b0, 32'hFFFF_FFFF, 0, -1, -1, 5);
        for (int c = 0; c < 5; c++) begin
            chk("t3_no_activity", {29'd0, tr_rd_en[c], tr_wen[c], tr_rv[c]}, 32'd0);
            chk("t3_done", {31'd0, tr_done[c]}, {31'd0, (c == 1)});
            chk("t3_busy", {31'd0, tr_busy[c]}, {31'd0, (c == 1)});
        end
        wait_idle();

        // 4: address wrap
        run_job(4, 'h3FE, 1'b0, 32'hFFFF_FFFF, 0, -1, -1, 10);
        chk("t4_addr0", {22'd0, tr_addr[1]}, 32'h3FE);
        chk("t4_addr1", {22'd0, tr_addr[2]}, 32'h3FF);
        chk("t4_addr2", {22'd0, tr_addr[3]}, 32'h000);
        chk("t4_addr3", {22'd0, tr_addr[4]}, 32'h001);
        wait_idle();

        // 5: sink stalls 5 cycles; a start mid-job is ignored
        run_job(2, 'h20, 1'b0, 32'hFFFF_FFFF, 10, 3, -1, 14);
        for (int c = 0; c < 14; c++) begin
            chk("t5_res_valid", {31'd0, tr_rv[c]}, {31'd0, (c >= 5 && c <= 10)});
            chk("t5_done", {31'd0, tr_done[c]}, {31'd0, (c == 11)});
        end
        chk("t5_idle_after", {31'd0, tr_busy[12]}, 32'd0);
        wait_idle();

        // 6: overflow pulse mid-job is sticky, cleared by next start
        run_job(4, 'h00, 1'b0, 32'hFFFF_FFFF, 0, -1, 4, 12);
        for (int c = 0; c < 12; c++)
            chk("t6_ovf_flag", {31'd0, tr_ovf[c]}, {31'd0, (c >= 5)});
        wait_idle();
        @(negedge clk);
        chk("t6_ovf_idle", {31'd0, ovf_flag}, 32'd1);
        step();
        run_job(1, 'h00, 1'b0, 32'hFFFF_FFFF, 0, -1, -1, 4);
        chk("t6_ovf_before_start", {31'd0, tr_ovf[0]}, 32'd1);
        chk("t6_ovf_cleared", {31'd0, tr_ovf[1]}, 32'd0);
        wait_idle();

        // reset in ISSUE
        start = 1; len = 10'd8; base = 10'h100; abs_mode = 1; rd_gnt = 1;
        step();
        start = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_mid_job", {13'd0, rd_en, rd_addr, w_en, mult, acc, abs_o, res_valid, busy,
                            done, ovf_flag}, 32'd0);
        step();

        // randomized phase, opened with a maximum-length job
        start = 1; len = 10'd1023; base = 10'($urandom_range(0, 1023)); abs_mode = 1;
        for (int i = 0; i < 4500; i++) begin
            step();
            start     = ($urandom_range(0, 5) == 0);
            len       = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
            base      = 10'($urandom_range(0, 1023));
            abs_mode  = $urandom_range(0, 1) == 1;
            rd_gnt    = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 1) == 1);
            overflow  = ($urandom_range(0, 29) == 0);
            rst       = (i > 2000) && ($urandom_range(0, 399) == 0);
        end
        step();
        rst = 0;
        overflow = 0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
